// File: rtl/instruction_decode.sv
// LEGv8 ID stage: control decode, 32x64 register file with
// write-through bypass, load-use stall and ID/EX register.
module instruction_decode #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] if_Address,
  input  logic [31:0]     if_Instruction,
  input  logic            if_valid,
  input  logic            flush,
  input  logic            wb_RegWrite,
  input  logic [4:0]      wb_Reg2Write,
  input  logic [XLEN-1:0] wb_Data,
  output logic            stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] Address,
  output logic [31:0]     Instruction,
  output logic [XLEN-1:0] signExtInstr,
  output logic [XLEN-1:0] Data1,
  output logic [XLEN-1:0] Data2,
  output logic [1:0]      ALUSrc,
  output logic [1:0]      ALUOp,
  output logic            B,
  output logic            BZ,
  output logic            BNZ,
  output logic            MemWrite,
  output logic            MemRead,
  output logic            MemtoReg,
  output logic            RegWrite,
  output logic            illegal
);

  localparam logic [4:0]  XZR    = 5'(NREGS - 1);
  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [10:0] OP_LD  = 11'b11111000010;
  localparam logic [10:0] OP_ST  = 11'b11111000000;

  // {ALUSrc, ALUOp, B, BZ, BNZ, MemWrite, MemRead,
  //  MemtoReg, RegWrite, illegal}
  localparam logic [11:0] C_R    = 12'b00_10_00000010;
  localparam logic [11:0] C_I    = 12'b10_11_00000010;
  localparam logic [11:0] C_LD   = 12'b01_00_00001110;
  localparam logic [11:0] C_ST   = 12'b01_00_00010000;
  localparam logic [11:0] C_B    = 12'b00_01_10000000;
  localparam logic [11:0] C_CBZ  = 12'b00_01_01000000;
  localparam logic [11:0] C_CBNZ = 12'b00_01_00100000;
  localparam logic [11:0] C_ILL  = 12'b00_00_00000001;

  logic [XLEN-1:0] rf [NREGS-1];
  logic [10:0]     op;
  logic [31:0]     ins;
  logic            is_r, is_i, is_ld, is_st;
  logic            is_b, is_cbz, is_cbnz;
  logic [11:0]     ctl, ctl_q;
  logic [XLEN-1:0] sext;
  logic            use2;
  logic [4:0]      rn, idx2, ld_rt;
  logic [XLEN-1:0] rd1, rd2;
  logic            haz, issue;

  assign ins     = if_Instruction;
  assign op      = ins[31:21];
  assign is_r    = op inside {OP_ADD, OP_SUB, OP_AND, OP_ORR};
  assign is_i    = (op[10:1] == 10'b1001000100) ||
                   (op[10:1] == 10'b1101000100);
  assign is_ld   = (op == OP_LD);
  assign is_st   = (op == OP_ST);
  assign is_b    = (op[10:5] == 6'b000101);
  assign is_cbz  = (op[10:3] == 8'b10110100);
  assign is_cbnz = (op[10:3] == 8'b10110101);

  always_comb begin
    ctl  = '0;
    sext = '0;
    use2 = 1'b0;
    unique case (1'b1)
      is_r: begin
        ctl  = C_R;
        use2 = 1'b1;
      end
      is_i: begin
        ctl  = C_I;
        sext = {{(XLEN-12){1'b0}}, ins[21:10]};
      end
      is_ld: begin
        ctl  = C_LD;
        sext = {{(XLEN-9){ins[20]}}, ins[20:12]};
      end
      is_st: begin
        ctl  = C_ST;
        sext = {{(XLEN-9){ins[20]}}, ins[20:12]};
        use2 = 1'b1;
      end
      is_b: begin
        ctl  = C_B;
        sext = {{(XLEN-26){ins[25]}}, ins[25:0]};
      end
      is_cbz: begin
        ctl  = C_CBZ;
        sext = {{(XLEN-19){ins[23]}}, ins[23:5]};
        use2 = 1'b1;
      end
      is_cbnz: begin
        ctl  = C_CBNZ;
        sext = {{(XLEN-19){ins[23]}}, ins[23:5]};
        use2 = 1'b1;
      end
      default: ctl = C_ILL;
    endcase
  end

  assign rn   = ins[9:5];
  assign idx2 = is_r ? ins[20:16] : ins[4:0];

  // Same-cycle writeback is forwarded so no WB->ID hazard exists.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rn != XZR)
      rd1 = (wb_RegWrite && wb_Reg2Write == rn) ?
            wb_Data : rf[rn];
    if (idx2 != XZR)
      rd2 = (wb_RegWrite && wb_Reg2Write == idx2) ?
            wb_Data : rf[idx2];
  end

  assign ld_rt = Instruction[4:0];
  assign haz   = ex_valid && MemRead && RegWrite &&
                 (ld_rt != XZR) &&
                 ((ld_rt == rn) || (use2 && ld_rt == idx2));
  assign stall = !reset && !flush && if_valid && haz;
  assign issue = if_valid && !flush && !haz;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS - 1; i++)
        rf[i] <= '0;
    end else if (wb_RegWrite && wb_Reg2Write != XZR) begin
      rf[wb_Reg2Write] <= wb_Data;
    end
  end

  // Bubbles clear valid/controls but keep the data fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ctl_q        <= '0;
      Address      <= '0;
      Instruction  <= '0;
      signExtInstr <= '0;
      Data1        <= '0;
      Data2        <= '0;
    end else begin
      ex_valid <= issue;
      ctl_q    <= issue ? ctl : '0;
      if (issue) begin
        Address      <= if_Address;
        Instruction  <= ins;
        signExtInstr <= sext;
        Data1        <= rd1;
        Data2        <= rd2;
      end
    end
  end

  assign {ALUSrc, ALUOp, B, BZ, BNZ, MemWrite,
          MemRead, MemtoReg, RegWrite, illegal} = ctl_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: driver pushes expected
// ID/EX contents, a negedge monitor pops and compares.
module tb_instruction_decode;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] ins;
    logic [63:0] sx;
    logic [63:0] d1;
    logic [63:0] d2;
    logic [11:0] ctl;
  } exp_t;

  localparam logic [11:0] C_R    = 12'b00_10_00000010;
  localparam logic [11:0] C_I    = 12'b10_11_00000010;
  localparam logic [11:0] C_LD   = 12'b01_00_00001110;
  localparam logic [11:0] C_ST   = 12'b01_00_00010000;
  localparam logic [11:0] C_B    = 12'b00_01_10000000;
  localparam logic [11:0] C_CBZ  = 12'b00_01_01000000;
  localparam logic [11:0] C_CBNZ = 12'b00_01_00100000;
  localparam logic [11:0] C_ILL  = 12'b00_00_00000001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] if_Address = '0;
  logic [31:0] if_Instruction = '0;
  logic        if_valid = 1'b0;
  logic        flush = 1'b0;
  logic        wb_RegWrite = 1'b0;
  logic [4:0]  wb_Reg2Write = '0;
  logic [63:0] wb_Data = '0;
  logic        stall, ex_valid;
  logic [63:0] Address, signExtInstr, Data1, Data2;
  logic [31:0] Instruction;
  logic [1:0]  ALUSrc, ALUOp;
  logic        B, BZ, BNZ, MemWrite, MemRead;
  logic        MemtoReg, RegWrite, illegal;

  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [63:0] pc = 64'h1000;

  instruction_decode dut (
    .clk(clk), .reset(reset),
    .if_Address(if_Address),
    .if_Instruction(if_Instruction),
    .if_valid(if_valid), .flush(flush),
    .wb_RegWrite(wb_RegWrite),
    .wb_Reg2Write(wb_Reg2Write),
    .wb_Data(wb_Data),
    .stall(stall), .ex_valid(ex_valid),
    .Address(Address), .Instruction(Instruction),
    .signExtInstr(signExtInstr),
    .Data1(Data1), .Data2(Data2),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp),
    .B(B), .BZ(BZ), .BNZ(BNZ),
    .MemWrite(MemWrite), .MemRead(MemRead),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f_r(
    input logic [10:0] o, input logic [4:0] rm,
    input logic [4:0] rn, input logic [4:0] rd);
    return {o, rm, 6'd0, rn, rd};
  endfunction

  function automatic logic [31:0] f_d(
    input logic [10:0] o, input logic [8:0] im,
    input logic [4:0] rn, input logic [4:0] rt);
    return {o, im, 2'b00, rn, rt};
  endfunction

  function automatic logic [31:0] f_i(
    input logic [9:0] o, input logic [11:0] im,
    input logic [4:0] rn, input logic [4:0] rd);
    return {o, im, rn, rd};
  endfunction

  function automatic logic [31:0] f_cb(
    input logic [7:0] o, input logic [18:0] im,
    input logic [4:0] rt);
    return {o, im, rt};
  endfunction

  function automatic logic [31:0] f_b(input logic [25:0] im);
    return {6'b000101, im};
  endfunction

  function automatic exp_t act();
    return {Address, Instruction, signExtInstr, Data1, Data2,
            ALUSrc, ALUOp, B, BZ, BNZ, MemWrite, MemRead,
            MemtoReg, RegWrite, illegal};
  endfunction

  task automatic step(
    input logic rst, input logic v, input logic fl,
    input logic [31:0] ins, input logic we,
    input logic [4:0] wr, input logic [63:0] wd,
    input logic xst, input logic push,
    input logic [63:0] sx, input logic [63:0] d1,
    input logic [63:0] d2, input logic [11:0] ctl);
    @(posedge clk);
    #2;
    reset          = rst;
    if_valid       = v;
    flush          = fl;
    if_Instruction = ins;
    if_Address     = pc;
    wb_RegWrite    = we;
    wb_Reg2Write   = wr;
    wb_Data        = wd;
    if (push) q.push_back({pc, ins, sx, d1, d2, ctl});
    pc = pc + 64'd4;
    #1;
    checks++;
    if (stall !== xst) begin
      errors++;
      $display("FAIL stall @%0t got %b want %b",
               $time, stall, xst);
    end
  endtask

  task automatic wb(input logic [4:0] r, input logic [63:0] d);
    step(0, 0, 0, '0, 1, r, d, 0, 0, '0, '0, '0, '0);
  endtask

  task automatic iss(
    input logic [31:0] ins, input logic [63:0] sx,
    input logic [63:0] d1, input logic [63:0] d2,
    input logic [11:0] ctl);
    step(0, 1, 0, ins, 0, 0, '0, 0, 1, sx, d1, d2, ctl);
  endtask

  task automatic stl(input logic [31:0] ins);
    step(0, 1, 0, ins, 0, 0, '0, 1, 0, '0, '0, '0, '0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (ex_valid) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL issue @%0t got %h want none",
                   $time, act());
        end else begin
          exp_t e;
          e = q.pop_front();
          if (act() !== e) begin
            errors++;
            $display("FAIL idex @%0t got %h want %h",
                     $time, act(), e);
          end
        end
      end else if (act().ctl !== 12'd0) begin
        errors++;
        $display("FAIL bubble_ctl @%0t got %h want 000",
                 $time, act().ctl);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ld9, add_h, add_m;
    ld9   = f_d(11'h7C2, 9'd0, 5'd1, 5'd9);
    add_h = f_r(11'h458, 5'd2, 5'd9, 5'd10);
    add_m = f_r(11'h458, 5'd9, 5'd2, 5'd10);

    step(1, 0, 0, '0, 0, 0, '0, 0, 0, '0, '0, '0, '0);
    wb(5'd5, 64'h55);
    step(1, 1, 0, f_r(11'h458, 5'd5, 5'd5, 5'd6),
         1, 5'd7, 64'h77, 0, 0, '0, '0, '0, '0);
    step(1, 0, 0, '0, 0, 0, '0, 0, 0, '0, '0, '0, '0);
    @(posedge clk);
    #1;
    checks++;
    if ({ex_valid, act()} !== '0) begin
      errors++;
      $display("FAIL reset_state got %b/%h want 0/0",
               ex_valid, act());
    end

    iss(f_r(11'h458, 5'd5, 5'd5, 5'd6), 0, 0, 0, C_R);
    wb(5'd1, 64'h10);
    wb(5'd2, 64'h5);
    iss(f_r(11'h458, 5'd2, 5'd1, 5'd3), 0, 64'h10, 64'h5, C_R);
    step(0, 1, 0, f_r(11'h658, 5'd2, 5'd2, 5'd4),
         1, 5'd2, 64'hABCD, 0, 1,
         0, 64'hABCD, 64'hABCD, C_R);
    wb(5'd9, 64'h99);
    step(0, 1, 0, f_r(11'h550, 5'd31, 5'd31, 5'd5),
         1, 5'd31, 64'h7, 0, 1, 0, 0, 0, C_R);
    iss(f_i(10'h244, 12'hFFF, 5'd1, 5'd7),
        64'hFFF, 64'h10, 0, C_I);
    iss(f_i(10'h344, 12'h123, 5'd2, 5'd8),
        64'h123, 64'hABCD, 0, C_I);
    iss(f_r(11'h450, 5'd2, 5'd1, 5'd11),
        0, 64'h10, 64'hABCD, C_R);
    iss(f_d(11'h7C2, 9'h1F8, 5'd1, 5'd9),
        64'hFFFF_FFFF_FFFF_FFF8, 64'h10, 64'h99, C_LD);
    iss(f_b(26'h2000000),
        64'hFFFF_FFFF_FE00_0000, 0, 0, C_B);
    iss(f_cb(8'hB4, 19'h7FFFF, 5'd9),
        64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h99, C_CBZ);
    iss(f_cb(8'hB5, 19'd4, 5'd2), 64'd4, 0, 64'hABCD, C_CBNZ);
    iss(f_d(11'h7C0, 9'd16, 5'd2, 5'd1),
        64'd16, 64'hABCD, 64'h10, C_ST);

    iss(ld9, 0, 64'h10, 64'h99, C_LD);
    stl(add_h);
    iss(add_h, 0, 64'h99, 64'hABCD, C_R);
    iss(ld9, 0, 64'h10, 64'h99, C_LD);
    iss(f_r(11'h458, 5'd3, 5'd2, 5'd10),
        0, 64'hABCD, 0, C_R);
    iss(ld9, 0, 64'h10, 64'h99, C_LD);
    stl(add_m);
    iss(add_m, 0, 64'hABCD, 64'h99, C_R);
    iss(ld9, 0, 64'h10, 64'h99, C_LD);
    iss(f_i(10'h244, 12'd1, 5'd1, 5'd9),
        64'd1, 64'h10, 64'h99, C_I);
    iss(f_d(11'h7C2, 9'd0, 5'd1, 5'd31), 0, 64'h10, 0, C_LD);
    iss(f_r(11'h458, 5'd2, 5'd31, 5'd10),
        0, 0, 64'hABCD, C_R);

    iss(ld9, 0, 64'h10, 64'h99, C_LD);
    step(0, 1, 1, add_h, 0, 0, '0, 0, 0, '0, '0, '0, '0);
    iss(ld9, 0, 64'h10, 64'h99, C_LD);
    step(0, 0, 0, add_h, 0, 0, '0, 0, 0, '0, '0, '0, '0);
    iss(32'h0000_0000, 0, 0, 0, C_ILL);

    repeat (3)
      step(0, 0, 0, '0, 0, 0, '0, 0, 0, '0, '0, '0, '0);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
